// File: rtl/nrisc_pc_pkg.sv
// Shared types and helpers for the nRisc fetch-address generator.
//   redirect_cause_t : why the pc took its most recent value
//   level_width()    : width of a stack occupancy count for a given depth
package nrisc_pc_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_JUMP_BR = 2'd1,
    CAUSE_CALL    = 2'd2,
    CAUSE_RET     = 2'd3
  } redirect_cause_t;

  // The count has to represent 0..depth inclusive, hence depth+1.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_STACK_DEPTH = 4;
  localparam int DEFAULT_LEVEL_W     = level_width(DEFAULT_STACK_DEPTH);

endpackage

// File: rtl/pc_stack_unit_return_stack.sv
// return_stack: LIFO of return addresses for the nRisc fetch unit.
// Ports:
//   clock, reset : negedge clock, synchronous active-high reset (clears level)
//   push, din    : store din on top; ignored when full
//   pop          : discard top entry; ignored when empty (pop wins over push)
//   top          : current top entry (zero when empty)
//   level        : number of valid entries
//   full, empty  : occupancy flags
module return_stack
  import nrisc_pc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int LVL_W = level_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [LVL_W-1:0] level_m1;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign level_m1 = level - LVL_W'(1);
  assign push_idx = level[IDX_W-1:0];
  assign top_idx  = level_m1[IDX_W-1:0];
  assign top      = empty ? '0 : mem[top_idx];

  always_ff @(negedge clock) begin
    if (reset) begin
      level <= '0;
    end else if (pop && !empty) begin
      level <= level_m1;
    end else if (push && !full) begin
      level <= level + LVL_W'(1);
    end
  end

  // Entry contents need no reset: only entries below level are ever read.
  always_ff @(negedge clock) begin
    if (!reset && !(pop && !empty) && push && !full) begin
      mem[push_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: fetch-address generator for the nRisc pipeline.
// All state updates on the falling clock edge.
// Ports:
//   clock, reset          : clock; synchronous active-high reset
//   stall                 : freeze pc and stack, ignore every request
//   jump, jump_target     : absolute redirect
//   branch, branch_offset : pc-relative redirect (signed offset)
//   call                  : push pc+1, redirect to jump_target
//   ret                   : pop return address into pc
//   pc                    : current fetch address
//   jumped                : high for the cycle after a taken redirect
//   redirect_cause        : cause of the most recent pc update
//   stack_level           : number of valid return addresses
//   overflow, underflow   : sticky misuse flags, cleared by reset only
// Request priority: reset > stall > ret > call > jump > branch > increment.
module pc_stack_unit
  import nrisc_pc_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int LVL_W = level_width(STACK_DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [PC_W-1:0]  jump_target,
  input  logic [OFF_W-1:0] branch_offset,
  output logic [PC_W-1:0]  pc,
  output logic             jumped,
  output redirect_cause_t  redirect_cause,
  output logic [LVL_W-1:0] stack_level,
  output logic             overflow,
  output logic             underflow
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_sext;
  logic [PC_W-1:0] stack_top;
  logic            stack_full;
  logic            stack_empty;

  logic            push;
  logic            pop;
  logic [PC_W-1:0] pc_next;
  logic            jumped_next;
  redirect_cause_t cause_next;
  logic            ovf_set;
  logic            unf_set;

  assign pc_inc   = pc + PC_W'(1);
  // Size-casting a signed operand sign-extends it to the pc width.
  assign off_sext = PC_W'($signed(branch_offset));

  always_comb begin
    pc_next     = pc_inc;
    jumped_next = 1'b0;
    cause_next  = CAUSE_NONE;
    push        = 1'b0;
    pop         = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    if (stall) begin
      pc_next = pc;
    end else if (ret) begin
      if (!stack_empty) begin
        pc_next     = stack_top;
        pop         = 1'b1;
        jumped_next = 1'b1;
        cause_next  = CAUSE_RET;
      end else begin
        // Empty-stack return degrades to a plain increment.
        unf_set = 1'b1;
      end
    end else if (call) begin
      // The redirect is taken even when the push must be dropped.
      push        = !stack_full;
      ovf_set     = stack_full;
      pc_next     = jump_target;
      jumped_next = 1'b1;
      cause_next  = CAUSE_CALL;
    end else if (jump) begin
      pc_next     = jump_target;
      jumped_next = 1'b1;
      cause_next  = CAUSE_JUMP_BR;
    end else if (branch) begin
      pc_next     = pc + off_sext;
      jumped_next = 1'b1;
      cause_next  = CAUSE_JUMP_BR;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      pc             <= RESET_PC;
      jumped         <= 1'b0;
      redirect_cause <= CAUSE_NONE;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      pc             <= pc_next;
      jumped         <= jumped_next;
      redirect_cause <= cause_next;
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  return_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (stack_top),
    .level (stack_level),
    .full  (stack_full),
    .empty (stack_empty)
  );

endmodule
